// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the fetch PC, issues one outstanding word read
// at a time over req/ack, and buffers tagged instructions in a small FIFO for decode.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   fpc_q, fpc_d;
  logic [63:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [63:0]   pc_mem_q   [DEPTH];

  logic          xfer;
  logic          pop;
  logic          push;
  logic          room_next;
  logic [63:0]   redirect_target;
  logic [63:0]   addr_inc;
  logic          unused_redirect_lsbs;

  assign xfer                 = req_q & imem_ack;
  assign pop                  = (count_q != '0) & inst_ready;
  assign push                 = (state_q == S_WAIT) & xfer & ~redirect_valid;
  assign redirect_target      = {redirect_pc[63:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign addr_inc             = addr_q + 64'd4;

  // The occupancy after this edge already counts the response still in flight,
  // so a new request is only issued when its data is guaranteed a slot.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  assign room_next = (count_d < CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    if (redirect_valid) begin
      fpc_d = redirect_target;
    end
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && room_next) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = fpc_q;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // Without an ack the request must stay up; its data is thrown away in DROP.
          if (xfer) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = S_DROP;
          end
        end else if (xfer) begin
          fpc_d = addr_inc;
          if (room_next) begin
            addr_d = addr_inc;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (xfer) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= addr_q;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed phases plus random traffic, with a scoreboard
// fed by a protocol-level model of the fetch stream and a decoupled monitor.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b1;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  // Memory returns the low address word as the instruction.
  assign imem_rdata = imem_addr[31:0];

  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory ack generator ----------------
  int ack_mode = 0;   // 0: always ack, 1: 3-cycle stall, 2: random, 3: never
  int wait_cnt = 0;
  bit xfer_seen = 1'b0;
  bit req_seen = 1'b0;

  always @(negedge clk) begin
    xfer_seen = imem_req && imem_ack;
    req_seen  = imem_req;
  end

  always @(posedge clk) begin
    #1;
    if (xfer_seen || !req_seen) wait_cnt = 0;
    else wait_cnt++;
    case (ack_mode)
      0: imem_ack = 1'b1;
      1: imem_ack = (wait_cnt >= 3);
      2: imem_ack = ($urandom_range(0, 2) == 0);
      default: imem_ack = 1'b0;
    endcase
  end

  // ---------------- reference model + monitor ----------------
  logic [63:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [63:0] exp_fetch = RST_PC;
  bit          drop_pend = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] stall_addr = 64'h0;

  always @(negedge clk) begin
    logic        xfer;
    logic        pop;
    logic [63:0] epc;
    logic [31:0] ein;
    if (reset) begin
      exp_pc_q.delete();
      exp_inst_q.delete();
      exp_fetch  = RST_PC;
      drop_pend  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("req_held", 64'(imem_req), 64'd1);
        check("addr_held", imem_addr, stall_addr);
      end
      check("valid_vs_model", 64'(inst_valid), 64'(exp_pc_q.size() != 0));
      if (exp_pc_q.size() == DEPTH) check("req_off_when_full", 64'(imem_req), 64'd0);
      xfer       = imem_req && imem_ack;
      pop        = inst_valid && inst_ready;
      stall_prev = imem_req && !imem_ack;
      stall_addr = imem_addr;
      if (redirect_valid) begin
        exp_pc_q.delete();
        exp_inst_q.delete();
        drop_pend = imem_req && !imem_ack;
        exp_fetch = {redirect_pc[63:2], 2'b00};
        $display("redirect target=%h drop=%0d", exp_fetch, drop_pend);
      end else begin
        if (pop) begin
          if (exp_pc_q.size() == 0) begin
            check("pop_on_empty", 64'(inst_valid), 64'd0);
          end else begin
            epc = exp_pc_q.pop_front();
            ein = exp_inst_q.pop_front();
            check("inst_pc", inst_pc, epc);
            check("inst", 64'(inst), 64'(ein));
            n_pop++;
            $display("pop pc=%h inst=%h", inst_pc, inst);
          end
        end
        if (xfer) begin
          if (drop_pend) begin
            drop_pend = 1'b0;
          end else begin
            check("fetch_addr", imem_addr, exp_fetch);
            exp_pc_q.push_back(exp_fetch);
            exp_inst_q.push_back(exp_fetch[31:0]);
            exp_fetch = exp_fetch + 64'd4;
            n_push++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] old_addr;
    int          p0;
    bit          seen;

    // Reset state
    tick();
    tick();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", imem_addr, RST_PC);

    // Streaming: one instruction per cycle
    tick();
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", 64'(inst_valid), 64'd1);
      check("stream_pc", inst_pc, RST_PC + 64'(4 * k));
      tick();
    end

    // Three-cycle ack stall: one transfer every four cycles
    ack_mode = 1;
    repeat (8) tick();
    p0 = n_push;
    repeat (40) tick();
    check("stall_rate", 64'(n_push - p0), 64'd10);

    // Full queue with decode stalled
    ack_mode   = 0;
    inst_ready = 1'b0;
    pulse_redirect(64'h100);
    repeat (20) tick();
    check("full_valid", 64'(inst_valid), 64'd1);
    check("full_head", inst_pc, 64'h100);
    check("full_req", 64'(imem_req), 64'd0);
    inst_ready = 1'b1;
    repeat (10) tick();

    // Redirect while a request is stalled
    ack_mode = 3;
    repeat (3) tick();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (imem_req && !imem_ack) seen = 1'b1;
      else tick();
    end
    check("stall_setup", 64'(seen), 64'd1);
    old_addr = imem_addr;
    pulse_redirect(64'h2002);
    check("drop_flush", 64'(inst_valid), 64'd0);
    check("drop_req", 64'(imem_req), 64'd1);
    check("drop_addr", imem_addr, old_addr);
    repeat (3) tick();
    ack_mode = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (inst_valid) seen = 1'b1;
      else tick();
    end
    check("drop_recover", 64'(seen), 64'd1);
    check("drop_first_pc", inst_pc, 64'h2000);
    repeat (5) tick();

    // Redirect coincident with a transfer and a pop
    check("coin_setup", 64'(inst_valid && imem_req && imem_ack), 64'd1);
    pulse_redirect(64'h3000);
    check("coin_flush", 64'(inst_valid), 64'd0);
    check("coin_idle", 64'(imem_req), 64'd0);
    tick();
    check("coin_req", 64'(imem_req), 64'd1);
    check("coin_addr", imem_addr, 64'h3000);
    repeat (4) tick();

    // Address wrap
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 64'h0);
    repeat (5) tick();

    // Random traffic
    ack_mode = 2;
    for (int k = 0; k < 1500; k++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {$urandom, $urandom};
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    ack_mode       = 0;
    repeat (10) tick();

    // Asynchronous reset in the middle of a stall
    inst_ready = 1'b0;
    pulse_redirect(64'h500);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (inst_valid) seen = 1'b1;
      else tick();
    end
    ack_mode = 3;
    repeat (2) tick();
    check("arst_setup", 64'(inst_valid && imem_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_valid", 64'(inst_valid), 64'd0);
    check("arst_addr", imem_addr, RST_PC);
    tick();
    reset      = 1'b0;
    inst_ready = 1'b1;
    ack_mode   = 0;
    repeat (12) tick();
    check("post_rst_stream", 64'(inst_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the LEGv8 core. Owns the fetch program counter and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned instructions, tagged with their PC, are buffered in a small FIFO. Decode drains the FIFO with a valid/ready handshake, and a branch redirect flushes the stage.

## Interface
- DEPTH, 4: fetch queue entries (power of two, ≥2)
- RESET_PC, 64'h0: first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory (registered)
- imem_addr  out  64  word-aligned read address (registered)
- imem_ack  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ack
- redirect_valid  in  1  branch taken; flush and refetch
- redirect_pc  in  64  new fetch target; bits [1:0] ignored (forced 0)
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  64  address of queue head instruction
- inst_ready  in  1  decode consumes head when inst_valid && inst_ready

## Operation
- State: fpc (64b), FIFO (count 0..DEPTH, rd/wr pointers), FSM {IDLE, WAIT, DROP}.
- Transfer: rising edge with imem_req && imem_ack. Pop: rising edge with inst_valid && inst_ready.
- Request rules:
  - imem_req and imem_addr are held stable from assertion until transfer.
  - imem_req is never withdrawn without a transfer.
  - At most one request is outstanding.
- IDLE:
  - With no redirect and count_next < DEPTH: go to WAIT; imem_req=1, imem_addr=fpc.
  - Otherwise remain in IDLE.
- WAIT, on transfer without redirect:
  - Push {imem_rdata, imem_addr}; fpc <= imem_addr+4.
  - If count_next < DEPTH: stay in WAIT and present the new address next cycle, giving back-to-back fetch.
  - Otherwise go to IDLE with imem_req=0.
- count_next = count + push − pop, evaluated on the same edge. This reserves the slot for the single outstanding response, so the FIFO never overflows.
- Redirect (highest priority, any state):
  - Flush FIFO (count=0); any same-cycle pop or push is discarded.
  - fpc <= {redirect_pc[63:2], 2'b00}.
- Redirect in IDLE, or in WAIT coinciding with a transfer: the returned data is discarded and the FSM goes to IDLE. A fetch of the new PC starts the next cycle.
- Redirect in WAIT without a transfer: go to DROP. imem_req stays high at the old address.
- DROP:
  - Wait for the transfer and discard its data, then go to IDLE.
  - A further redirect in DROP only updates fpc.
- Arithmetic: fpc+4 is modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Output: inst/inst_pc come from the head entry and are undefined when inst_valid=0.

## Timing
- Reset (async) state:
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, count=0, FSM=IDLE, fpc=RESET_PC.
  - An in-flight request is abandoned; the memory is reset by the same signal.
- First imem_req=1 in the first cycle after the first clock edge following reset release.
- Fetch latency: transfer at edge N gives inst_valid=1 after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle with zero-wait ack and inst_ready held high.
- Redirect penalty: redirect at edge N puts imem_addr=redirect target after edge N+1, or after the drop ack plus one cycle.
- Full queue: imem_req=0 until a pop. The request reissues the cycle after the pop.
- Empty queue: inst_valid=0; inst_ready is ignored.

## Test plan
- Reset, RESET_PC=0x100, ack always 1, ready always 1, rdata=addr[31:0]:
  - required: inst_pc sequence 0x100, 0x104, 0x108 … on consecutive cycles, with inst equal to the matching address.
- ack stalls 3 cycles per request:
  - required: imem_addr stable during each stall and exactly one push per transfer, so one instruction is delivered every 4 cycles.
- ready=0 for 20 cycles with ack=1:
  - required: count reaches DEPTH=4 (PCs 0x100–0x10C) and imem_req drops.
  - Raising ready drains 0x100…0x10C in order and the fetch of 0x110 resumes.
- Redirect to 0x2002 while a request to 0x108 is stalled (ack=0):
  - required: FIFO empties immediately and imem_req stays on 0x108 until ack; that data is dropped.
  - The next request is 0x2000, and the first delivered inst_pc is 0x2000.
- Redirect coincident with a transfer and a pop:
  - required: nothing delivered or pushed from old path; next imem_addr equals the redirect target.
- fpc at 0xFFFF_FFFF_FFFF_FFFC via redirect:
  - required: next address 0x0. Asserting reset mid-stall clears inst_valid and imem_req immediately, without waiting for a clock edge.
